// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the arbiter and the unified memory port.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        bus_error;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_ready, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output stall, bus_error
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_ready, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  stall, bus_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch (IF) and load/store (DM).
// Define ARB_ROUND_ROBIN_EN to replace DM priority + starvation forcing with round-robin.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input logic            clk,
  input logic            resetn,
  mem_port_arbiter_if.slave bus
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = DM owns the transaction
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        bus_error_q, bus_error_d;
  logic        grant_dm;
  logic        any_req;
  logic        contested;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm_q, last_dm_d;  // resets to IF so DM wins the first contest
`else
  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
`endif

  assign any_req   = bus.if_req | bus.dm_req;
  assign contested = bus.if_req & bus.dm_req;

  always_comb begin
    grant_dm = bus.dm_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (contested) grant_dm = ~last_dm_q;
`else
    if (contested && (starve_q == StarveLimit)) grant_dm = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    tmo_d       = tmo_q;
    bus_error_d = bus_error_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_dm_d   = last_dm_q;
`else
    starve_d    = starve_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = grant_dm;
          tmo_d   = 8'd0;
          state_d = StBusy;
          if (grant_dm) begin
            we_d    = bus.dm_we;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
            wstrb_d = bus.dm_wstrb;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            wstrb_d = 4'b0000;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_dm_d = grant_dm;
`else
          if (!grant_dm) begin
            starve_d = 4'd0;
          end else if (contested && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
          end
`endif
        end
      end

      StBusy: begin
        if (bus.mem_ready) begin
          state_d = StResp;
          if (!owner_q) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
        end else if (tmo_q == TimeoutLast) begin
          state_d     = StResp;
          bus_error_d = 1'b1;
          if (owner_q) dm_rdata_d = ERR_DATA;
          else         if_rdata_d = ERR_DATA;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      tmo_q       <= '0;
      bus_error_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q   <= 1'b0;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      tmo_q       <= tmo_d;
      bus_error_q <= bus_error_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q   <= last_dm_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign bus.mem_en    = (state_q == StBusy);
  assign bus.mem_we    = (state_q == StBusy) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.if_ack    = (state_q == StResp) & ~owner_q;
  assign bus.dm_ack    = (state_q == StResp) & owner_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.bus_error = bus_error_q;
  assign bus.stall     = (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (DM) of the pipelined core. It arbitrates, registers the winning transaction, drives the memory port until it reports ready, returns read data with a one-cycle ack pulse, and raises stall so the pipeline registers freeze while a requester waits. It sits between the PC/IF_ID fetch path, the Data_Memory access path and the physical memory.

Parameters:
STARVE_LIMIT, 3, consecutive IDLE arbitrations IF may lose before it is forced to win (1..15)
TIMEOUT, 16, BUSY cycles without mem_ready before a bus error is declared (2..255)
ERR_DATA, 32'hDEADBEEF, rdata returned on a timed-out transaction

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous reset, active-high (1 = reset asserted)
if_req  in  1  fetch request, held until if_ack
if_addr  in  32  fetch address
if_ack  out  1  one-cycle completion pulse to IF
if_rdata  out  32  fetched word, registered
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  32  data address
dm_wdata  in  32  store data
dm_wstrb  in  4  store byte enables
dm_ack  out  1  one-cycle completion pulse to DM
dm_rdata  out  32  load word, registered
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte enables
mem_ready  in  1  memory completes access this cycle
mem_rdata  in  32  memory read data, valid with mem_ready
stall  out  1  pipeline freeze request
bus_error  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state): FSM -> IDLE; all outputs 0, including rdata regs, starve count, timeout count and bus_error; any in-flight transaction is abandoned with no ack.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req is high, pick a winner, latch its addr/we/wdata/wstrb into the mem_* output regs, record the owner, and go to BUSY. If no req is high, stay in IDLE.
- IF transactions always drive mem_we = 0 and mem_wstrb = 0.
- Arbitration: DM wins over IF, except that IF wins when the starve count equals STARVE_LIMIT.
- Starve count: increments, saturating, each time IF loses a contested arbitration; cleared when IF is granted.
- BUSY: mem_en = 1 with the mem_* regs stable.
  - On mem_ready = 1: capture mem_rdata into the owner's rdata reg (loads and fetches only; a store leaves dm_rdata unchanged), then go to RESP.
  - Timeout count increments each BUSY cycle without mem_ready. On reaching TIMEOUT: the owner's rdata = ERR_DATA, bus_error is set, then go to RESP.
- RESP: mem_en = 0; the owner's ack = 1 for exactly this cycle; go to IDLE.
- Requester handshake: a requester must drop or replace its request at the edge that ends RESP. Req sampled in the following IDLE cycle is a new request.
- Minimum latency with mem_ready tied high: req in cycle 0 (IDLE), BUSY in cycle 1, ack in cycle 2. Back-to-back service takes 3 cycles per transaction.
- Requests are never preempted; a request arriving during BUSY/RESP waits for the next IDLE.
- mem_addr/mem_wdata/mem_wstrb hold their last values outside BUSY. mem_en and mem_we are 0 outside BUSY.
- rdata regs hold until that port's next completion.
- stall = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
- bus_error clears only on reset.
- Address alignment is not checked; addresses pass through unmodified.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: fixed DM priority and the starve counter are removed. A last-grant bit selects priority; on contention the port not granted last wins. The last-grant bit resets to IF, so DM wins the first contested arbitration.
- Undefined: DM priority with STARVE_LIMIT forcing, as above.

Test Plan:
- mem_ready = 1, IF-only fetch: if_req = 1, if_addr = 0x00000004, mem_rdata = 0x00500093 -> mem_en in cycle 1 with mem_addr = 0x4; if_ack in cycle 2; if_rdata = 0x00500093; stall high in cycles 0-1.
- Store: dm_req = 1, dm_we = 1, dm_addr = 0x100, dm_wdata = 0xCAFEF00D, dm_wstrb = 4'b0011 -> mem_we = 1 and mem_wstrb = 0011 in BUSY; dm_ack one cycle; dm_rdata unchanged.
- Both requests held continuously, default build, STARVE_LIMIT = 3 -> grant order DM, DM, DM, IF, DM, DM, DM, IF. No double ack; each ack lasts exactly 1 cycle.
- mem_ready held 0 with TIMEOUT = 16, DM load -> ack after 16 BUSY cycles; dm_rdata = 0xDEADBEEF; bus_error = 1 and stays 1 through later good accesses.
- resetn pulsed during BUSY with mem_ready low -> all outputs 0 asynchronously; no ack issued; a new IF request after release completes normally in 3 cycles.
- ARB_ROUND_ROBIN_EN defined, both requests held -> grants alternate DM, IF, DM, IF.
